// File: rtl/fifo_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_test_pkg
// Description : Shared types and constants for the FIFO pattern writer.
//               Holds the FSM state encoding and the hold/stall counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_test_pkg;

  localparam int HOLD_CNT_W = 16;
  localparam int STALL_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_pattern_writer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pattern_writer
// Description : Writes an incrementing data pattern into a FIFO, throttled by
//               prog_full (with a programmable quiet-period hold-off) and
//               back-pressured by full. Optional fixed-length bursts.
// Ports       : prg_clk      - clock, rising edge
//               prg_rst_n    - asynchronous active-low reset
//               enable       - start / continue writing while high
//               prog_full    - FIFO programmable-full throttle (may pulse)
//               full         - FIFO hard full
//               wr_en        - FIFO write strobe (combinational)
//               din          - FIFO write data, incrementing pattern
//               word_count   - cumulative words written since reset
//               stall_cycles - saturating count of cycles spent in HOLD
//               done         - high while the burst has completed
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_pattern_writer
  import fifo_test_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 16,
  parameter int BURST_LEN   = 0
) (
  input  logic               prg_clk,
  input  logic               prg_rst_n,
  input  logic               enable,
  input  logic               prog_full,
  input  logic               full,
  output logic               wr_en,
  output logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  word_count,
  output logic [STALL_W-1:0] stall_cycles,
  output logic               done
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_RELOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [DATA_W-1:0]     BURST_LIMIT = DATA_W'(BURST_LEN);
  localparam logic [STALL_W-1:0]    STALL_MAX   = {STALL_W{1'b1}};
  localparam bit                    BURST_ON    = (BURST_LEN != 0);

  state_e                state_q,      state_d;
  logic [DATA_W-1:0]     din_q,        din_d;
  logic [DATA_W-1:0]     word_count_q, word_count_d;
  logic [DATA_W-1:0]     burst_cnt_q,  burst_cnt_d;
  logic [HOLD_CNT_W-1:0] hold_cnt_q,   hold_cnt_d;
  logic [STALL_W-1:0]    stall_q,      stall_d;

  logic                  wr_fire;
  logic [DATA_W-1:0]     burst_next;

  always_ff @(posedge prg_clk or negedge prg_rst_n) begin
    if (!prg_rst_n) begin
      state_q      <= ST_IDLE;
      din_q        <= '0;
      word_count_q <= '0;
      burst_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      word_count_q <= word_count_d;
      burst_cnt_q  <= burst_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      stall_q      <= stall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    din_d        = din_q;
    word_count_d = word_count_q;
    burst_cnt_d  = burst_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    stall_d      = stall_q;

    // A write only happens in WRITE with both throttles clear; enable is
    // deliberately absent so the cycle that drops enable still writes.
    wr_fire    = (state_q == ST_WRITE) && !prog_full && !full;
    burst_next = burst_cnt_q + 1'b1;

    if (wr_fire) begin
      din_d        = din_q + 1'b1;
      word_count_d = word_count_q + 1'b1;
      burst_cnt_d  = burst_next;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_WRITE;
          burst_cnt_d = '0;
        end
      end

      ST_WRITE: begin
        // Burst completion wins over everything: the final write of a burst
        // can never be followed by a HOLD.
        if (BURST_ON && wr_fire && (burst_next == BURST_LIMIT)) begin
          state_d = ST_DONE;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end else if (prog_full) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_RELOAD;
        end
      end

      ST_HOLD: begin
        if (stall_q != STALL_MAX) begin
          stall_d = stall_q + 1'b1;
        end
        // Any prog_full during the quiet period restarts the full wait.
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (prog_full) begin
          hold_cnt_d = HOLD_RELOAD;
        end else if (hold_cnt_q == '0) begin
          state_d = ST_WRITE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end

      ST_DONE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_en        = wr_fire;
  assign din          = din_q;
  assign word_count   = word_count_q;
  assign stall_cycles = stall_q;
  assign done         = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_pattern_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_pattern_writer
// Description : Directed self-checking bench for fifo_pattern_writer.
//               dut_a: defaults (32-bit, HOLD 16, unlimited burst)
//               dut_b: BURST_LEN=4
//               dut_c: DATA_W=8 for pattern wrap
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_pattern_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        en_a, pf_a, fu_a, wr_a, done_a;
  logic [31:0] din_a, wc_a;
  logic [15:0] st_a;

  logic        en_b, pf_b, fu_b, wr_b, done_b;
  logic [31:0] din_b, wc_b;
  logic [15:0] st_b;

  logic        en_c, pf_c, fu_c, wr_c, done_c;
  logic [7:0]  din_c, wc_c;
  logic [15:0] st_c;

  fifo_pattern_writer #(.DATA_W(32), .HOLD_CYCLES(16), .BURST_LEN(0)) dut_a (
    .prg_clk(clk), .prg_rst_n(rst_n), .enable(en_a), .prog_full(pf_a),
    .full(fu_a), .wr_en(wr_a), .din(din_a), .word_count(wc_a),
    .stall_cycles(st_a), .done(done_a)
  );

  fifo_pattern_writer #(.DATA_W(32), .HOLD_CYCLES(16), .BURST_LEN(4)) dut_b (
    .prg_clk(clk), .prg_rst_n(rst_n), .enable(en_b), .prog_full(pf_b),
    .full(fu_b), .wr_en(wr_b), .din(din_b), .word_count(wc_b),
    .stall_cycles(st_b), .done(done_b)
  );

  fifo_pattern_writer #(.DATA_W(8), .HOLD_CYCLES(16), .BURST_LEN(0)) dut_c (
    .prg_clk(clk), .prg_rst_n(rst_n), .enable(en_c), .prog_full(pf_c),
    .full(fu_c), .wr_en(wr_c), .din(din_c), .word_count(wc_c),
    .stall_cycles(st_c), .done(done_c)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs are driven there and
  // outputs are sampled one further ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ea;
    logic [7:0]  ec;
    int          low;

    rst_n = 1'b0;
    en_a = 0; pf_a = 0; fu_a = 0;
    en_b = 0; pf_b = 0; fu_b = 0;
    en_c = 0; pf_c = 0; fu_c = 0;

    // ---------------- reset state ----------------
    #2;
    check_eq("rst_wr_a",   wr_a,   0);
    check_eq("rst_din_a",  din_a,  0);
    check_eq("rst_wc_a",   wc_a,   0);
    check_eq("rst_st_a",   st_a,   0);
    check_eq("rst_done_a", done_a, 0);
    check_eq("rst_done_b", done_b, 0);
    check_eq("rst_din_c",  din_c,  0);
    tick;
    tick;
    rst_n = 1'b1;

    // ---------------- basic write: 10 words, one-cycle latency ----------------
    en_a = 1'b1;
    #1 check_eq("basic_idle_wr", wr_a, 0);
    tick;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) en_a = 1'b0;   // last write still completes
      #1;
      check_eq("basic_wr", wr_a, 1);
      check_eq("basic_din", din_a, 64'(i));
      tick;
    end
    #1;
    check_eq("basic_wc", wc_a, 10);
    check_eq("basic_din_end", din_a, 10);
    check_eq("basic_wr_off", wr_a, 0);
    tick;

    // ---------------- periodic prog_full pulses ----------------
    ea = 32'd10;
    en_a = 1'b1;
    #1 check_eq("thr_idle_wr", wr_a, 0);
    tick;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < 5; j++) begin
        #1;
        check_eq("thr_wr", wr_a, 1);
        check_eq("thr_din", din_a, 64'(ea));
        ea = ea + 1;
        tick;
      end
      pf_a = 1'b1;
      #1 check_eq("thr_pulse_wr", wr_a, 0);
      tick;
      pf_a = 1'b0;
      low = 1;
      #1;
      for (int k = 0; k < 40 && wr_a == 1'b0; k++) begin
        low++;
        tick;
        #1;
      end
      check_eq("thr_low_cycles", 64'(low), 17);
      check_eq("thr_din_contig", din_a, 64'(ea));
      check_eq("thr_stall", st_a, 64'(16 * (p + 1)));
      ea = ea + 1;
      tick;
    end

    // ---------------- back-pressure via full ----------------
    fu_a = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      check_eq("bp_wr", wr_a, 0);
      check_eq("bp_din_frozen", din_a, 64'(ea));
      tick;
    end
    fu_a = 1'b0;
    #1;
    check_eq("bp_resume_wr", wr_a, 1);
    check_eq("bp_resume_din", din_a, 64'(ea));
    check_eq("bp_stall_same", st_a, 32);
    ea = ea + 1;
    tick;
    en_a = 1'b0;
    #1 check_eq("bp_last_wr", wr_a, 1);
    ea = ea + 1;
    tick;
    #1;
    check_eq("bp_wc", wc_a, 64'(ea));
    check_eq("bp_idle_wr", wr_a, 0);
    tick;

    // ---------------- burst end: BURST_LEN=4 ----------------
    en_b = 1'b1;
    #1 check_eq("burst_idle_wr", wr_b, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("burst_wr", wr_b, 1);
      check_eq("burst_din", din_b, 64'(i));
      tick;
    end
    pf_b = 1'b1;   // throttle arrives right after the final write
    #1;
    check_eq("burst_done", done_b, 1);
    check_eq("burst_done_wr", wr_b, 0);
    tick;
    #1;
    check_eq("burst_still_done", done_b, 1);
    check_eq("burst_no_hold", st_b, 0);
    check_eq("burst_wc", wc_b, 4);
    pf_b = 1'b0;
    en_b = 1'b0;
    tick;
    #1 check_eq("burst_idle_done", done_b, 0);
    en_b = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("burst2_wr", wr_b, 1);
      check_eq("burst2_din", din_b, 64'(4 + i));
      tick;
    end
    #1;
    check_eq("burst2_done", done_b, 1);
    check_eq("burst2_wc", wc_b, 8);
    en_b = 1'b0;
    tick;

    // ---------------- 8-bit wrap: 300 writes ----------------
    en_c = 1'b1;
    tick;
    for (int i = 0; i < 300; i++) begin
      if (i == 299) en_c = 1'b0;
      ec = 8'(i);
      #1;
      check_eq("wrap_wr", wr_c, 1);
      check_eq("wrap_din", din_c, 64'(ec));
      tick;
    end
    #1;
    check_eq("wrap_wc", wc_c, 44);
    check_eq("wrap_din_end", din_c, 44);
    check_eq("wrap_wr_off", wr_c, 0);
    tick;

    // ---------------- asynchronous reset mid-HOLD ----------------
    en_a = 1'b1;
    tick;           // WRITE
    pf_a = 1'b1;
    tick;           // HOLD
    pf_a = 1'b0;
    tick;
    tick;
    #1 check_eq("pre_rst_stall", st_a, 34);
    #1 rst_n = 1'b0;   // mid-cycle, no clock edge
    #1;
    check_eq("arst_wr", wr_a, 0);
    check_eq("arst_din", din_a, 0);
    check_eq("arst_wc", wc_a, 0);
    check_eq("arst_stall", st_a, 0);
    check_eq("arst_done_b", done_b, 0);
    en_a = 1'b0;
    #1 rst_n = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("post_rst_wr", wr_a, 0);
      tick;
    end
    en_a = 1'b1;
    #1 check_eq("post_rst_idle_wr", wr_a, 0);
    tick;
    #1;
    check_eq("post_rst_first_wr", wr_a, 1);
    check_eq("post_rst_din", din_a, 0);
    en_a = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
